// File: rtl/stitch_pkg.sv
// Shared types and helpers for the stitching output timing / tile layout block.
package stitch_pkg;

    localparam int MAX_GRID = 8;
    localparam int MAX_CW   = 16;
    localparam int SPLIT_W  = (MAX_GRID - 1) * MAX_CW;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
        logic frame_start;
    } raster_t;

    // Split entries are packed at a stride of the instantiating block's counter width.
    typedef struct packed {
        logic [SPLIT_W-1:0]             col_split;
        logic [SPLIT_W-1:0]             row_split;
        logic [MAX_GRID*MAX_GRID-1:0]   tile_en;
    } tile_cfg_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [SPLIT_W-1:0] even_splits(input int active, input int n, input int cw);
        logic [SPLIT_W-1:0] s;
        s = '0;
        for (int i = 0; i < MAX_GRID - 1; i++) begin
            s = (i < n - 1) ? (s | (SPLIT_W'((i + 1) * active / n) << (i * cw))) : s;
        end
        return s;
    endfunction

    function automatic tile_cfg_t default_cfg(input int h_act, input int v_act,
                                              input int cols, input int rows, input int cw);
        tile_cfg_t c;
        c.col_split = even_splits(h_act, cols, cw);
        c.row_split = even_splits(v_act, rows, cw);
        c.tile_en   = '1;
        return c;
    endfunction

endpackage

// File: rtl/stitch_split_lookup.sv
// Maps a coordinate onto a set of ascending split points: grid index and local offset.
module stitch_split_lookup #(
    parameter int NUM   = 2,
    parameter int CNT_W = 12,
    localparam int NS    = (NUM > 1) ? NUM - 1 : 1,
    localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic [CNT_W-1:0]    coord_i,
    input  logic [NS*CNT_W-1:0] split_i,
    output logic [IDX_W-1:0]    idx_o,
    output logic [CNT_W-1:0]    offset_o
);

    logic [CNT_W-1:0] base_s;

    // Last split not above the coordinate selects the cell and its origin.
    always_comb begin
        idx_o  = '0;
        base_s = '0;
        for (int i = 0; i < NUM - 1; i++) begin
            idx_o  = (split_i[i*CNT_W +: CNT_W] <= coord_i) ? IDX_W'(i + 1) : idx_o;
            base_s = (split_i[i*CNT_W +: CNT_W] <= coord_i) ? split_i[i*CNT_W +: CNT_W] : base_s;
        end
        offset_o = coord_i - base_s;
    end

endmodule

// File: rtl/stitch_layout_timing.sv
// Raster timing generator with runtime-programmable tile grid mapping and
// per-tile line prefetch requests; layout changes take effect on frame boundaries.
module stitch_layout_timing
    import stitch_pkg::*;
#(
    parameter int H_ACTIVE  = 1920,
    parameter int H_FP      = 88,
    parameter int H_SYNC    = 44,
    parameter int H_BP      = 148,
    parameter int V_ACTIVE  = 1080,
    parameter int V_FP      = 4,
    parameter int V_SYNC    = 5,
    parameter int V_BP      = 36,
    parameter int TILE_COLS = 2,
    parameter int TILE_ROWS = 2,
    parameter int PREFETCH  = 64,
    parameter int CNT_W     = 12,
    localparam int NUM_CH   = TILE_COLS * TILE_ROWS,
    localparam int ID_W     = id_width(NUM_CH),
    localparam int CS_W     = ((TILE_COLS > 1) ? TILE_COLS - 1 : 1) * CNT_W,
    localparam int RS_W     = ((TILE_ROWS > 1) ? TILE_ROWS - 1 : 1) * CNT_W
) (
    input  logic              video_clk,
    input  logic              rst,
    input  logic              en,
    input  logic [CS_W-1:0]   cfg_col_split,
    input  logic [RS_W-1:0]   cfg_row_split,
    input  logic [NUM_CH-1:0] cfg_tile_en,
    input  logic              cfg_update,
    output logic              cfg_pending,
    output logic              video_vsync,
    output logic              video_hsync,
    output logic              video_de,
    output logic              frame_start,
    output logic [CNT_W-1:0]  pix_x,
    output logic [CNT_W-1:0]  pix_y,
    output logic [ID_W-1:0]   tile_id,
    output logic [CNT_W-1:0]  tile_x,
    output logic [CNT_W-1:0]  tile_y,
    output logic              tile_valid,
    output logic [NUM_CH-1:0] line_req,
    output logic [CNT_W-1:0]  line_req_y
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int CIW     = id_width(TILE_COLS);
    localparam int RIW     = id_width(TILE_ROWS);

    localparam logic [CNT_W-1:0] H_START = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] H_END   = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CNT_W-1:0] V_START = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] V_END   = CNT_W'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_REQ   = CNT_W'(H_TOTAL - PREFETCH);
    localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_SYNC);

    localparam tile_cfg_t          DEF_CFG = default_cfg(H_ACTIVE, V_ACTIVE, TILE_COLS, TILE_ROWS, CNT_W);
    localparam logic [CS_W-1:0]    DEF_COL = DEF_CFG.col_split[CS_W-1:0];
    localparam logic [RS_W-1:0]    DEF_ROW = DEF_CFG.row_split[RS_W-1:0];
    localparam logic [NUM_CH-1:0]  DEF_EN  = DEF_CFG.tile_en[NUM_CH-1:0];

    logic [CNT_W-1:0]  h_q, h_d, v_q, v_d;
    logic              wrap_s;
    logic [CS_W-1:0]   col_q, col_sh_q;
    logic [RS_W-1:0]   row_q, row_sh_q;
    logic [NUM_CH-1:0] ten_q, ten_sh_q;
    logic              pend_q;

    raster_t           ras_s;
    logic              h_act_s, v_act_s, req_s;
    logic [CNT_W-1:0]  px_s, py_s, tx_s, ty_s, nv_s, ny_s, nty_s;
    logic [CIW-1:0]    col_idx_s;
    logic [RIW-1:0]    row_idx_s, nrow_s;
    logic [ID_W-1:0]   id_s;
    logic [NUM_CH-1:0] lreq_s;

    // Raster counter next state; dropping en parks the raster at the origin.
    always_comb begin
        h_d    = '0;
        v_d    = '0;
        wrap_s = 1'b0;
        if (en) begin
            if (h_q == H_LAST) begin
                h_d    = '0;
                v_d    = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
                wrap_s = (v_q == V_LAST);
            end else begin
                h_d = h_q + CNT_W'(1);
                v_d = v_q;
            end
        end else begin
            h_d = '0;
            v_d = '0;
        end
    end

    // Raster counters.
    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // Shadow capture and frame-boundary apply; an update on the apply cycle stays pending.
    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            col_q    <= DEF_COL;
            row_q    <= DEF_ROW;
            ten_q    <= DEF_EN;
            col_sh_q <= '0;
            row_sh_q <= '0;
            ten_sh_q <= '0;
            pend_q   <= 1'b0;
        end else begin
            if (wrap_s && pend_q) begin
                col_q <= col_sh_q;
                row_q <= row_sh_q;
                ten_q <= ten_sh_q;
            end
            if (cfg_update) begin
                col_sh_q <= cfg_col_split;
                row_sh_q <= cfg_row_split;
                ten_sh_q <= cfg_tile_en;
                pend_q   <= 1'b1;
            end else if (wrap_s) begin
                pend_q <= 1'b0;
            end
        end
    end

    // Region decode of the current counter state and next-line prefetch qualification.
    always_comb begin
        h_act_s           = (h_q >= H_START) && (h_q < H_END);
        v_act_s           = (v_q >= V_START) && (v_q < V_END);
        ras_s.hsync       = en && (h_q < HS_END);
        ras_s.vsync       = en && (v_q < VS_END);
        ras_s.de          = en && h_act_s && v_act_s;
        ras_s.frame_start = en && (h_q == '0) && (v_q == '0);
        px_s              = ras_s.de ? h_q - H_START : '0;
        py_s              = ras_s.de ? v_q - V_START : '0;
        nv_s              = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
        req_s             = en && (h_q == H_REQ) && (nv_s >= V_START) && (nv_s < V_END);
        ny_s              = req_s ? nv_s - V_START : '0;
    end

    stitch_split_lookup #(.NUM(TILE_COLS), .CNT_W(CNT_W)) u_col_lookup (
        .coord_i  (px_s),
        .split_i  (col_q),
        .idx_o    (col_idx_s),
        .offset_o (tx_s)
    );

    stitch_split_lookup #(.NUM(TILE_ROWS), .CNT_W(CNT_W)) u_row_lookup (
        .coord_i  (py_s),
        .split_i  (row_q),
        .idx_o    (row_idx_s),
        .offset_o (ty_s)
    );

    stitch_split_lookup #(.NUM(TILE_ROWS), .CNT_W(CNT_W)) u_req_lookup (
        .coord_i  (ny_s),
        .split_i  (row_q),
        .idx_o    (nrow_s),
        .offset_o (nty_s)
    );

    // Tile id of the current pixel and the set of enabled tiles in the next line's row.
    always_comb begin
        id_s   = ras_s.de ? ID_W'(row_idx_s * TILE_COLS + col_idx_s) : '0;
        lreq_s = '0;
        for (int t = 0; t < NUM_CH; t++) begin
            lreq_s[t] = req_s && ten_q[t] && (RIW'(t / TILE_COLS) == nrow_s);
        end
    end

    // Output register stage, one cycle behind the counter state.
    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            video_hsync <= 1'b0;
            video_vsync <= 1'b0;
            video_de    <= 1'b0;
            frame_start <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            tile_id     <= '0;
            tile_x      <= '0;
            tile_y      <= '0;
            tile_valid  <= 1'b0;
            line_req    <= '0;
            line_req_y  <= '0;
        end else begin
            video_hsync <= ras_s.hsync;
            video_vsync <= ras_s.vsync;
            video_de    <= ras_s.de;
            frame_start <= ras_s.frame_start;
            pix_x       <= px_s;
            pix_y       <= py_s;
            tile_id     <= id_s;
            tile_x      <= ras_s.de ? tx_s : '0;
            tile_y      <= ras_s.de ? ty_s : '0;
            tile_valid  <= ras_s.de && ten_q[id_s];
            line_req    <= lreq_s;
            line_req_y  <= req_s ? nty_s : '0;
        end
    end

    assign cfg_pending = pend_q;

endmodule

// File: tb/tb_stitch_layout_timing.sv
// Scoreboard bench: stimulus queues expected pixels / line requests, a negedge monitor checks them.
module tb_stitch_layout_timing;

    localparam int CW = 12;

    logic          video_clk = 1'b0;
    logic          rst, en, cfg_update;
    logic [CW-1:0] cfg_col_split, cfg_row_split;
    logic [3:0]    cfg_tile_en;
    logic          cfg_pending, video_vsync, video_hsync, video_de, frame_start, tile_valid;
    logic [CW-1:0] pix_x, pix_y, tile_x, tile_y, line_req_y;
    logic [1:0]    tile_id;
    logic [3:0]    line_req;

    stitch_layout_timing #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .TILE_COLS(2), .TILE_ROWS(2), .PREFETCH(3), .CNT_W(CW)
    ) dut (
        .video_clk(video_clk), .rst(rst), .en(en),
        .cfg_col_split(cfg_col_split), .cfg_row_split(cfg_row_split),
        .cfg_tile_en(cfg_tile_en), .cfg_update(cfg_update), .cfg_pending(cfg_pending),
        .video_vsync(video_vsync), .video_hsync(video_hsync), .video_de(video_de),
        .frame_start(frame_start), .pix_x(pix_x), .pix_y(pix_y), .tile_id(tile_id),
        .tile_x(tile_x), .tile_y(tile_y), .tile_valid(tile_valid),
        .line_req(line_req), .line_req_y(line_req_y)
    );

    always #5 video_clk = ~video_clk;

    typedef struct { int x; int y; int id; int tx; int ty; int v; } pix_t;
    typedef struct { int bits; int ly; int off; } req_t;
    typedef struct { int f; int x; int y; int id; int tx; int ty; int v; } hand_t;

    pix_t  de_exp[$];
    req_t  req_exp[$];
    hand_t hand[8];
    int    checks = 0;
    int    failures = 0;
    int    g = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int pos(input int f, input int v, input int h);
        return 264 * f + 24 * v + h;
    endfunction

    // Expected pixel stream and line requests for one frame of a 2x2 layout.
    task automatic push_frame(input int f, input int cs, input int rs, input logic [3:0] en4);
        pix_t p;
        req_t r;
        int   row;
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 16; x++) begin
                p.x  = x;
                p.y  = y;
                p.id = ((y >= rs) ? 2 : 0) + ((x >= cs) ? 1 : 0);
                p.tx = (x >= cs) ? x - cs : x;
                p.ty = (y >= rs) ? y - rs : y;
                p.v  = en4[p.id] ? 1 : 0;
                for (int k = 0; k < 8; k++) begin
                    if (hand[k].f == f && hand[k].x == x && hand[k].y == y) begin
                        p.id = hand[k].id;
                        p.tx = hand[k].tx;
                        p.ty = hand[k].ty;
                        p.v  = hand[k].v;
                    end
                end
                de_exp.push_back(p);
            end
        end
        for (int y = 0; y < 8; y++) begin
            row    = (y >= rs) ? 1 : 0;
            r.ly   = (y >= rs) ? y - rs : y;
            r.off  = 24 * (y + 1) + 21;
            r.bits = 0;
            for (int t = 0; t < 4; t++) begin
                if (en4[t] && (t / 2) == row) r.bits = r.bits | (1 << t);
            end
            if (r.bits != 0) req_exp.push_back(r);
        end
    endtask

    task automatic wait_to(input int e);
        while (g < e) begin
            @(posedge video_clk);
            g++;
        end
        #1;
    endtask

    task automatic do_update(input int cs, input logic [3:0] en4);
        cfg_col_split = CW'(cs);
        cfg_row_split = CW'(4);
        cfg_tile_en   = en4;
        cfg_update    = 1'b1;
        @(posedge video_clk);
        g++;
        #1;
        cfg_update = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a pixel or a request.
    initial begin
        int   off = 0;
        bit   have_prev = 0;
        int   hs_n = 0, vs_n = 0, de_n = 0;
        pix_t p;
        req_t r;
        forever begin
            @(negedge video_clk);
            if (rst) begin
                have_prev = 0;
                off = 0;
                hs_n = 0; vs_n = 0; de_n = 0;
            end else begin
                if (frame_start) begin
                    if (have_prev) begin
                        check("frame_len", off + 1, 264);
                        check("hsync_count", hs_n, 22);
                        check("vsync_count", vs_n, 24);
                        check("de_count", de_n, 128);
                    end
                    have_prev = 1;
                    off = 0;
                    hs_n = 0; vs_n = 0; de_n = 0;
                end else begin
                    off++;
                end
                hs_n += video_hsync;
                vs_n += video_vsync;
                de_n += video_de;
                if (video_de) begin
                    if (de_exp.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL de_unexpected: got pixel (%0d,%0d) expected none", pix_x, pix_y);
                    end else begin
                        p = de_exp.pop_front();
                        check("pixel", {pix_x, pix_y, 2'b00, tile_id, tile_x, tile_y, 3'b000, tile_valid},
                              {CW'(p.x), CW'(p.y), 4'(p.id), CW'(p.tx), CW'(p.ty), 4'(p.v)});
                    end
                end else begin
                    check("idle_zero", {pix_x, pix_y, tile_id, tile_x, tile_y, tile_valid}, '0);
                end
                if (line_req != 4'd0) begin
                    if (req_exp.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL req_unexpected: got line_req=%b at offset %0d expected none", line_req, off);
                    end else begin
                        r = req_exp.pop_front();
                        check("line_req", {16'(off), line_req, line_req_y},
                              {16'(r.off), 4'(r.bits), CW'(r.ly)});
                    end
                end
            end
        end
    end

    initial begin
        hand = '{'{0, 9, 5, 3, 1, 1, 1}, '{0, 7, 3, 0, 7, 3, 1},
                 '{2, 5, 0, 1, 0, 0, 1}, '{2, 4, 6, 2, 4, 2, 0},
                 '{3, 12, 7, 3, 0, 3, 1}, '{3, 11, 0, 0, 11, 0, 1},
                 '{4, 3, 0, 1, 0, 0, 1}, '{5, 8, 4, 3, 0, 0, 1}};
        rst = 1'b1;
        en = 1'b1;
        cfg_update = 1'b0;
        cfg_col_split = CW'(0);
        cfg_row_split = CW'(4);
        cfg_tile_en = 4'hF;
        repeat (3) @(posedge video_clk);
        #1;
        check("reset_outputs", {cfg_pending, video_vsync, video_hsync, video_de, frame_start, pix_x, pix_y,
                                tile_id, tile_x, tile_y, tile_valid, line_req, line_req_y}, '0);
        rst = 1'b0;
        g = 0;
        push_frame(0, 8, 4, 4'hF);

        wait_to(pos(1, 0, 0));
        push_frame(1, 8, 4, 4'hF);
        wait_to(pos(1, 4, 0));
        do_update(5, 4'b1011);
        check("pending_after_update", cfg_pending, 1'b1);

        wait_to(pos(2, 0, 0));
        push_frame(2, 5, 4, 4'b1011);
        wait_to(pos(2, 1, 0));
        check("pending_cleared", cfg_pending, 1'b0);
        wait_to(pos(2, 2, 0));
        do_update(7, 4'hF);
        wait_to(pos(2, 5, 0));
        do_update(12, 4'hF);
        check("pending_second_update", cfg_pending, 1'b1);
        wait_to(pos(2, 10, 23));
        do_update(3, 4'hF);
        check("pending_on_apply_update", cfg_pending, 1'b1);
        push_frame(3, 12, 4, 4'hF);
        wait_to(pos(3, 5, 0));
        check("pending_deferred", cfg_pending, 1'b1);

        wait_to(pos(4, 0, 0));
        push_frame(4, 3, 4, 4'hF);
        check("pending_after_deferred_apply", cfg_pending, 1'b0);
        wait_to(pos(4, 1, 0));
        do_update(6, 4'hF);
        check("pending_before_reset", cfg_pending, 1'b1);

        wait_to(pos(4, 3, 15));
        check("pix_before_reset", {video_de, pix_x, pix_y}, {1'b1, CW'(10), CW'(1)});
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {cfg_pending, video_vsync, video_hsync, video_de, frame_start, pix_x, pix_y,
                                      tile_id, tile_x, tile_y, tile_valid, line_req, line_req_y}, '0);
        de_exp.delete();
        req_exp.delete();
        repeat (2) @(posedge video_clk);
        #1;
        rst = 1'b0;
        g = 0;
        push_frame(5, 8, 4, 4'hF);
        wait_to(pos(0, 0, 1));
        check("restart_frame_start", {frame_start, video_hsync, video_vsync, cfg_pending}, 4'b1110);

        wait_to(pos(1, 0, 5));
        check("pixel_queue_drained", de_exp.size(), 0);
        check("req_queue_drained", req_exp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stitch_layout_timing.md
Name: stitch_layout_timing

Overview:
- Parametrised output-side timing and tile-layout generator for the stitching pipeline, running in the video_clk domain.
- Generates video_vsync/video_hsync/video_de for a configurable raster, and maps every active pixel to a tile of a TILE_COLS x TILE_ROWS grid, giving tile id and local x/y.
- Issues per-tile line-prefetch requests to the frame-buffer readers.
- Grid split points are runtime-programmable and applied only on frame boundaries, so layouts such as 960x1080 + 2x(960x540) or NxM mosaics need no RTL change.

Parameters:
H_ACTIVE 1920 active pixels per line
H_FP 88 horizontal front porch
H_SYNC 44 hsync width
H_BP 148 horizontal back porch
V_ACTIVE 1080 active lines
V_FP 4 vertical front porch
V_SYNC 5 vsync width, in lines
V_BP 36 vertical back porch
TILE_COLS 2 grid columns, 1..8
TILE_ROWS 2 grid rows, 1..8
PREFETCH 64 line_req lead in cycles before line end; 1..H_FP
CNT_W 12 counter and coordinate width
Localparams: H_TOTAL, V_TOTAL, NUM_CH=TILE_COLS*TILE_ROWS, ID_W=max(1,clog2(NUM_CH))

Ports:
video_clk in 1 clock
rst in 1 reset, asynchronous, active-high
en in 1 raster run enable
cfg_col_split in max(1,TILE_COLS-1)*CNT_W x split points, entry i at [i*CNT_W +: CNT_W]
cfg_row_split in max(1,TILE_ROWS-1)*CNT_W y split points
cfg_tile_en in NUM_CH per-tile enable
cfg_update in 1 pulse: capture cfg_* into shadow
cfg_pending out 1 shadow captured, not yet applied
video_vsync out 1 active-high vsync
video_hsync out 1 active-high hsync
video_de out 1 active pixel
frame_start out 1 one-cycle pulse at h=0,v=0
pix_x out CNT_W global active x
pix_y out CNT_W global active y
tile_id out ID_W row*TILE_COLS+col
tile_x out CNT_W tile-local x
tile_y out CNT_W tile-local y
tile_valid out 1 video_de AND cfg_tile_en[tile_id]
line_req out NUM_CH per-tile prefetch pulse
line_req_y out CNT_W tile-local line number for line_req

Behaviour:
- Reset (async, mid-operation included): all outputs 0, h_cnt=v_cnt=0, shadow and pending cleared. Active config loads defaults: col split i=(i+1)*H_ACTIVE/TILE_COLS, row split j=(j+1)*V_ACTIVE/TILE_ROWS, all tiles enabled.
- Counters:
  - en=0: h_cnt/v_cnt held at 0; outputs 0 from the next cycle.
  - en=1: h_cnt counts 0..H_TOTAL-1. v_cnt increments on h wrap, 0..V_TOTAL-1.
  - en deassert mid-frame clears immediately. Reassert restarts at h=v=0 with frame_start.
- Regions per axis, in order: SYNC [0,SYNC), BP, ACTIVE [SYNC+BP, SYNC+BP+ACTIVE), FP.
  - de = h ACTIVE && v ACTIVE.
  - pix_x=h_cnt-(H_SYNC+H_BP) and pix_y=v_cnt-(V_SYNC+V_BP) while de, else 0.
- Latency: every output is registered, one cycle after the counter state it reflects. All outputs are mutually aligned.
- Tile lookup:
  - col = count of col_split entries <= pix_x; row likewise on pix_y.
  - tile_x = pix_x - col_split[col-1], or pix_x when col=0. tile_y analogous.
  - tile_id/tile_x/tile_y are 0 when de=0.
  - Split points must be strictly ascending and < active size. Otherwise outputs are deterministic but meaningless; no checking.
- line_req:
  - Asserted at h_cnt==H_TOTAL-PREFETCH of line v when line v+1 (wrapping) is active.
  - Bit t pulses one cycle for each enabled tile whose row contains that next line.
  - line_req_y = next line's tile-local y.
  - No requests for lines outside the vertical active window.
- Config:
  - cfg_update captures all cfg_* into the shadow and sets cfg_pending. A later update before apply overwrites the shadow.
  - Apply happens in the cycle the counters wrap to h=0,v=0. Shadow becomes active and cfg_pending clears.
  - cfg_update coincident with apply is captured and deferred to the next frame.
  - Active config never changes mid-frame.

Decomposition:
- Package stitch_pkg: raster/timing struct typedef, tile_cfg_t (split arrays, enable mask), default-layout function, ID_W helper.
- One sub-module, stitch_split_lookup: coordinate plus split array -> index and local offset, instantiated for x and y.

Test Plan:
Common parameters: H_ACTIVE=16, H_FP=4, H_SYNC=2, H_BP=2 (H_TOTAL=24); V_ACTIVE=8, V_FP=V_SYNC=V_BP=1 (V_TOTAL=11); 2x2 grid; PREFETCH=3.
1. Release rst, en=1 -> hsync high 2 of every 24 cycles; vsync high 24 of 264; 128 de cycles per frame; frame_start every 264 cycles.
2. Default splits (8,4) -> pixel (9,5) gives tile_id=3, tile_x=1, tile_y=1. Pixel (7,3) gives tile_id=0, tile_x=7, tile_y=3.
3. Line-req timing:
   - Global line y=4 (v_cnt=6) -> line_req=4'b1100, line_req_y=0 at h_cnt=21 of v_cnt=5, single cycle.
   - Global line y=0 -> line_req=4'b0011 at v_cnt=1.
   - No line_req during v_cnt 9,10,0.
4. Mid-frame config update: col_split=5, tile_en=4'b1011, cfg_update at v_cnt=4 -> cfg_pending=1 and mapping unchanged for the rest of the frame.
   - Next frame: (5,0) gives tile 1, tile_x=0.
   - Tile 2 pixels: de=1, tile_valid=0.
   - line_req[2] never pulses.
5. rst asserted at pix_x=10 -> all outputs 0 asynchronously. After release: raster restarts at h=v=0, default layout restored, cfg_pending=0.
6. Second cfg_update in the same frame with col_split=12 -> value 12 applied at the boundary; update on the apply cycle is deferred one frame, with cfg_pending=1 throughout.
